// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
// Contents: round-count defaults, rk_idx width, the inverse S-box, GF(2^8) multiply helpers,
// the state byte-order helpers and the controller FSM state type.
// The package has no ports.
package aes_pkg;

    localparam int unsigned NR_DEFAULT = 10;
    localparam int unsigned RK_IDX_W   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StFinal = 2'd2,
        StDone  = 2'd3
    } aes_fsm_e;

    // Entry 0 sits in the most significant byte, so INV_SBOX[b] is InvSbox(b).
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Byte idx = 4*col + row; byte 0 occupies bits [127:120].
    function automatic logic [7:0] st_byte(input logic [127:0] s, input int idx);
        return s[127 - 8*idx -: 8];
    endfunction

    // One column {row0..row3}, row0 in the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
                gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
                gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
                gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
// Ports:
//   state_in  [127:0] round input state
//   rk        [127:0] round key for this round
//   last      1       final round, bypass InvMixColumns
//   state_out [127:0] round output state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [7:0]  w_isb [16];
    logic [7:0]  w_ark [16];
    logic [31:0] w_col [4];

    always_comb begin
        w_isb     = '{default: '0};
        w_ark     = '{default: '0};
        w_col     = '{default: '0};
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // Row r was rotated left by r on encrypt, so output column c reads column c-r.
                w_isb[4*c + r] = inv_sbox(st_byte(state_in, 4*((c + 4 - r) % 4) + r));
                w_ark[4*c + r] = w_isb[4*c + r] ^ st_byte(rk, 4*c + r);
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_col[c] = {w_ark[4*c], w_ark[4*c + 1], w_ark[4*c + 2], w_ark[4*c + 3]};
            state_out[127 - 32*c -: 32] = last ? w_col[c] : inv_mix_col(w_col[c]);
        end
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, round keys from an external store.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   ciphertext handshake
//   ct        [127:0]    ciphertext block
//   rk_idx    [3:0]      round-key index requested this cycle
//   rk        [127:0]    round key w[rk_idx], returned combinationally
//   out_valid, out_ready plaintext handshake
//   pt        [127:0]    plaintext block, valid while out_valid
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        ct,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        pt
);

    localparam logic [RK_IDX_W-1:0] RkLast  = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] CntInit = RK_IDX_W'(NR - 1);

    aes_fsm_e            r_fsm,  w_fsm_nxt;
    logic [127:0]        r_data, w_data_nxt;
    logic [RK_IDX_W-1:0] r_cnt,  w_cnt_nxt;
    logic [127:0]        w_round_out;
    logic                w_last;

    assign w_last = (r_fsm == StFinal);

    aes_inv_round u_round (
        .state_in  (r_data),
        .rk        (rk),
        .last      (w_last),
        .state_out (w_round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm  <= StIdle;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Outputs depend only on registers (plus out_ready for in_ready), so rk_idx moves on edges only.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_data_nxt = r_data;
        w_cnt_nxt  = r_cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rk_idx     = RkLast;
        unique case (r_fsm)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_data_nxt = ct ^ rk;
                    w_cnt_nxt  = CntInit;
                    w_fsm_nxt  = StRound;
                end
            end
            StRound: begin
                rk_idx     = r_cnt;
                w_data_nxt = w_round_out;
                w_cnt_nxt  = r_cnt - 1'b1;
                if (r_cnt == RK_IDX_W'(1)) begin
                    w_fsm_nxt = StFinal;
                end
            end
            StFinal: begin
                rk_idx     = '0;
                w_data_nxt = w_round_out;
                w_fsm_nxt  = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    // Consume the result and, if offered, load the next block on the same edge.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_data_nxt = ct ^ rk;
                        w_cnt_nxt  = CntInit;
                        w_fsm_nxt  = StRound;
                    end else begin
                        w_fsm_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_fsm_nxt = StIdle;
            end
        endcase
    end

    assign pt = r_data;

endmodule
